// File: rtl/imem_stream_loader_if.sv
// imem_stream_loader_if: bundles the byte-stream input, the imem write port and the
// loader status lines into one port.
// Modports:
//   master - the loader: consumes start/byte stream, drives imem writes and status.
//   slave  - the environment: drives start/byte stream, observes imem writes and status.
// Signals:
//   start        pulse that begins a load
//   byte_valid   byte_data is valid (source side of the byte handshake)
//   byte_data    stream byte
//   byte_ready   loader can take a byte this cycle
//   imem_we      one-cycle instruction-memory write strobe
//   imem_waddr   instruction-memory byte address
//   imem_wdata   instruction word
//   loader_done  image fully written (sticky)
//   core_rst_n   active-low core reset, mirrors loader_done
//   busy         transfer in progress
//   err          load aborted (sticky)
//   err_code     0 none, 1 count overflow, 2 timeout, 3 checksum
//   words_loaded words written so far
interface imem_stream_loader_if;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        loader_done;
  logic        core_rst_n;
  logic        busy;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] words_loaded;

  modport master (
    input  start,
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output imem_we,
    output imem_waddr,
    output imem_wdata,
    output loader_done,
    output core_rst_n,
    output busy,
    output err,
    output err_code,
    output words_loaded
  );

  modport slave (
    output start,
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  imem_we,
    input  imem_waddr,
    input  imem_wdata,
    input  loader_done,
    input  core_rst_n,
    input  busy,
    input  err,
    input  err_code,
    input  words_loaded
  );
endinterface

// File: rtl/imem_stream_loader.sv
// Purpose: loads an instruction image from a byte stream (4-byte LSB-first word count,
//          then N LSB-first words) into imem, then releases the core reset.
// Latency: one byte per cycle; each word is written in the cycle after its 4th byte.
// Backpressure: byte_ready drops during the write cycle and outside active transfer states.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset (core held in reset, all outputs 0)
//   bus  imem_stream_loader_if.master - byte stream in, imem write port and status out
// Parameters: BASE_ADDR (byte address of word 0), MAX_WORDS (largest accepted count),
//   TIMEOUT_CYCLES (idle cycles allowed between accepted bytes).
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a 4-byte LSB-first trailer
//   equal to the modulo-2^32 sum of all data words before the core is released.
module imem_stream_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  imem_stream_loader_if.master   bus
);

  localparam int IW = $clog2(MAX_WORDS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CHK   = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;
`endif

  state_t          r_state;
  state_t          w_next;

  logic [1:0]      r_bcnt;      // bytes collected in the current 4-byte group
  logic [23:0]     r_shift;     // first three bytes of the group, newest at the top
  logic [31:0]     r_n;         // word count from the header
  logic [IW-1:0]   r_idx;       // index of the next word to write
  logic [TW-1:0]   r_tmo;       // idle cycles since the last accepted byte
  logic [31:0]     r_waddr;
  logic [31:0]     r_wdata;
  logic [1:0]      r_err_code;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]     r_sum;
`endif

  logic            w_ready;
  logic            w_we;
  logic            w_busy;
  logic            w_done;
  logic            w_err;
  logic            w_waiting;
  logic            w_start_ok;
  logic            w_accept;
  logic            w_last;
  logic            w_tmo_hit;
  logic            w_err_set;
  logic [1:0]      w_err_val;
  logic [31:0]     w_word;
  logic [31:0]     w_idx_inc;
  logic [31:0]     w_addr;

  // Completed group as it would look if the byte on the bus is taken now.
  assign w_word    = {bus.byte_data, r_shift};
  assign w_accept  = bus.byte_valid & w_ready;
  assign w_last    = w_accept & (r_bcnt == 2'd3);
  assign w_tmo_hit = w_waiting & ~w_accept & (r_tmo == TMO_LAST);
  assign w_idx_inc = 32'(r_idx) + 32'd1;
  assign w_addr    = BASE_ADDR + (32'(r_idx) << 2);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and state-decoded outputs.
  always_comb begin
    w_next     = r_state;
    w_ready    = 1'b0;
    w_we       = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    w_err      = 1'b0;
    w_waiting  = 1'b0;
    w_start_ok = 1'b0;
    w_err_set  = 1'b0;
    w_err_val  = 2'd0;
    case (r_state)
      S_IDLE: begin
        w_start_ok = bus.start;
        if (bus.start) w_next = S_HDR;
      end
      S_DONE: begin
        w_done     = 1'b1;
        w_start_ok = bus.start;
        if (bus.start) w_next = S_HDR;
      end
      S_ERR: begin
        w_err      = 1'b1;
        w_start_ok = bus.start;
        if (bus.start) w_next = S_HDR;
      end
      S_HDR: begin
        w_ready   = 1'b1;
        w_busy    = 1'b1;
        w_waiting = 1'b1;
        if (w_tmo_hit) begin
          w_next    = S_ERR;
          w_err_set = 1'b1;
          w_err_val = 2'd2;
        end else if (w_last) begin
          if (w_word == 32'd0) begin
            w_next = S_DONE;
          end else if (w_word > 32'(MAX_WORDS)) begin
            w_next    = S_ERR;
            w_err_set = 1'b1;
            w_err_val = 2'd1;
          end else begin
            w_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        w_ready   = 1'b1;
        w_busy    = 1'b1;
        w_waiting = 1'b1;
        if (w_tmo_hit) begin
          w_next    = S_ERR;
          w_err_set = 1'b1;
          w_err_val = 2'd2;
        end else if (w_last) begin
          w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        w_we   = 1'b1;
        w_busy = 1'b1;
        if (w_idx_inc < r_n) begin
          w_next = S_DATA;
        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_next = S_CHK;
`else
          w_next = S_DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        w_ready   = 1'b1;
        w_busy    = 1'b1;
        w_waiting = 1'b1;
        if (w_tmo_hit) begin
          w_next    = S_ERR;
          w_err_set = 1'b1;
          w_err_val = 2'd2;
        end else if (w_last) begin
          if (w_word == r_sum) begin
            w_next = S_DONE;
          end else begin
            w_next    = S_ERR;
            w_err_set = 1'b1;
            w_err_val = 2'd3;
          end
        end
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: byte assembly, counters, write port registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcnt     <= 2'd0;
      r_shift    <= 24'd0;
      r_n        <= 32'd0;
      r_idx      <= '0;
      r_tmo      <= '0;
      r_waddr    <= 32'd0;
      r_wdata    <= 32'd0;
      r_err_code <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum      <= 32'd0;
`endif
    end else if (w_start_ok) begin
      // New load: wipe progress; the write port keeps its last values.
      r_bcnt     <= 2'd0;
      r_shift    <= 24'd0;
      r_n        <= 32'd0;
      r_idx      <= '0;
      r_tmo      <= '0;
      r_err_code <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum      <= 32'd0;
`endif
    end else begin
      if (w_accept) begin
        r_bcnt  <= r_bcnt + 2'd1;
        r_shift <= w_word[31:8];
        r_tmo   <= '0;
      end else if (w_waiting && (r_tmo != TMO_LAST)) begin
        r_tmo <= r_tmo + TW'(1);
      end

      if ((r_state == S_HDR) && w_last) begin
        r_n <= w_word;
      end

      // Capture address and data so they are stable during WRITE and hold afterwards.
      if ((r_state == S_DATA) && w_last) begin
        r_waddr <= w_addr;
        r_wdata <= w_word;
      end

      if (r_state == S_WRITE) begin
        r_idx <= r_idx + IW'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_sum <= r_sum + r_wdata;
`endif
      end

      if (w_err_set) begin
        r_err_code <= w_err_val;
      end
    end
  end

  assign bus.byte_ready   = w_ready;
  assign bus.imem_we      = w_we;
  assign bus.imem_waddr   = r_waddr;
  assign bus.imem_wdata   = r_wdata;
  assign bus.loader_done  = w_done;
  assign bus.core_rst_n   = w_done;
  assign bus.busy         = w_busy;
  assign bus.err          = w_err;
  assign bus.err_code     = r_err_code;
  assign bus.words_loaded = 16'(r_idx);

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Write-side master for the instruction-memory load port of the pipeline core.
- Accepts a byte stream from a serial receiver via a valid/ready handshake, then assembles little-endian 32-bit words.
- Issues one-cycle imem write strobes at incrementing word addresses.
- On completion raises the loader-done indication and releases the core's active-low reset.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction word.
- MAX_WORDS, 256, largest word count accepted in the header.
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between accepted bytes while a transfer is in progress.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle pulse that begins a load
- byte_valid  input  1  byte_data is valid
- byte_data  input  8  stream byte
- byte_ready  output  1  loader can accept a byte this cycle
- imem_we  output  1  instruction-memory write strobe
- imem_waddr  output  32  instruction-memory byte address
- imem_wdata  output  32  instruction word
- loader_done  output  1  image fully written; sticky
- core_rst_n  output  1  core reset, active-low; equals loader_done
- busy  output  1  transfer in progress
- err  output  1  load aborted; sticky
- err_code  output  2  0 none, 1 count overflow, 2 timeout, 3 checksum
- words_loaded  output  16  number of words written so far

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0 (core held in reset); byte counter, word index and timeout counter cleared.
- States: IDLE, HDR, DATA, WRITE, CHK (macro only), DONE, ERR.
- Byte handshake: a byte is accepted on a cycle where byte_valid and byte_ready are both 1.
  - byte_ready=1 only in HDR, DATA and CHK.
  - Bytes offered in any other state are not consumed.
- IDLE/DONE/ERR + start:
  - Go to HDR; clear loader_done, err, err_code, words_loaded and the counters; busy=1.
  - start is ignored in HDR, DATA, WRITE and CHK.
- HDR: collect 4 bytes, LSB first, into N (32-bit word count).
  - N=0 -> DONE.
  - N>MAX_WORDS -> ERR, err_code=1.
  - Otherwise -> DATA.
- DATA: collect 4 bytes LSB first into a word buffer. On the 4th accepted byte, go to WRITE.
- WRITE: exactly one cycle.
  - imem_we=1, imem_waddr=BASE_ADDR+4*idx, imem_wdata=buffer; byte_ready=0.
  - idx increments; words_loaded=idx+1.
  - Next state: DATA if idx+1<N; otherwise CHK if the macro is defined, else DONE.
  - imem_we is 0 in every other state; address and data hold their last values.
- DONE: loader_done=1, core_rst_n=1, busy=0. Holds until rst or start.
- ERR: err=1 (sticky), busy=0, loader_done=0. Writes already made are not undone.
- Timeout:
  - Counter runs only in HDR, DATA and CHK, and clears on every accepted byte.
  - Reaching TIMEOUT_CYCLES-1 with no byte accepted -> ERR, err_code=2. This applies before the first byte too.
- Arithmetic:
  - Address computed modulo 2^32; idx width is clog2(MAX_WORDS+1).
  - words_loaded is zero-extended or truncated to 16 bits.
- rst asserted mid-transfer aborts immediately to IDLE. A partially assembled word is discarded and never written.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, enter CHK and collect a 4-byte LSB-first trailer.
  - The trailer is compared with the modulo-2^32 sum of all N data words (running accumulator updated in WRITE).
  - Equal -> DONE. Mismatch -> ERR, err_code=3; core_rst_n stays 0.
  - N=0 still goes straight to DONE with no trailer.
- Undefined: no CHK state, no accumulator; err_code never takes the value 3.

Test Plan:
- Basic load: BASE_ADDR=0x100, start; stream 02 00 00 00, 13 05 10 00, 93 05 20 00.
  - Two imem_we pulses: (0x100, 0x00100513) and (0x104, 0x00200593).
  - Then loader_done=1, core_rst_n=1, words_loaded=2.
- Handshake gaps: same image with byte_valid de-asserted for 5 random cycles between bytes.
  - Identical writes; byte_ready=0 during each WRITE cycle; no bytes lost or duplicated.
- Overflow: MAX_WORDS=4, header 05 00 00 00 -> ERR, err_code=1, no imem_we pulses, core_rst_n=0.
- Timeout: TIMEOUT_CYCLES=16, header N=1, then 2 data bytes and silence.
  - ERR with err_code=2 after 16 idle cycles; no imem_we pulse.
  - A subsequent start and a valid image reaches DONE.
- Reset mid-operation: assert rst after the 3rd byte of word 1 -> all outputs 0 immediately.
  - A restart with N=1 writes at BASE_ADDR.
- Checksum (macro defined): words 0x00000001 and 0xFFFFFFFF.
  - Trailer 00 00 00 00 -> DONE.
  - Trailer 01 00 00 00 -> ERR, err_code=3.
